// File: rtl/p_accum.sv
// p_accum: saturating accumulator of NTERMS products with sticky ovf/udf/rounded flags (optional P_ACCUM_BIAS_EN bias port).
// Latency: result valid 1 cycle after the last accepted term; in_ready low while a result is held.
package p_accum_pkg;
  typedef enum logic [1:0] {DT_BOOL, DT_INT, DT_FXP, DT_FP} dtype_t;
  typedef struct packed {
    dtype_t     dtype;
    logic       sgn;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF '{dtype: p_accum_pkg::DT_INT, sgn: 1'b1, prec: 8'd8, frac: 8'd0}
`endif

module p_accum #(
  parameter p_accum_pkg::dconf_t I_CONF = `DEF_DCONF,
  parameter p_accum_pkg::dconf_t O_CONF = `DEF_DCONF,
  parameter int                  NTERMS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_CONF.prec-1:0] in,
  input  logic                   in_ovf,
  input  logic                   in_udf,
  input  logic                   in_rounded,
`ifdef P_ACCUM_BIAS_EN
  input  logic [O_CONF.prec-1:0] bias,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_CONF.prec-1:0] out,
  output logic                   out_ovf,
  output logic                   out_udf,
  output logic                   out_rounded
);

  localparam int   IW  = int'(I_CONF.prec);
  localparam int   OW  = int'(O_CONF.prec);
  localparam int   CW  = $clog2(NTERMS + 1);
  localparam logic SGN = O_CONF.sgn;

  if ((O_CONF.dtype != p_accum_pkg::DT_INT && O_CONF.dtype != p_accum_pkg::DT_FXP) ||
      (I_CONF.dtype != O_CONF.dtype) || (I_CONF.sgn != O_CONF.sgn) ||
      (O_CONF.dtype == p_accum_pkg::DT_FXP && I_CONF.frac != O_CONF.frac) ||
      (OW < IW) || (NTERMS < 1)) begin : g_bad_conf
    $error("p_accum: unsupported I_CONF/O_CONF/NTERMS combination");
  end

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [OW-1:0] acc;
  logic          f_ovf, f_udf, f_rnd;

  logic          accept, first, last, clamp;
  logic [OW-1:0] base, sat_val, acc_nxt;
  logic [OW:0]   in_ext, base_ext, sum;

  assign accept = in_valid && in_ready;
  assign first  = (cnt == '0);
  assign last   = (cnt == CW'(NTERMS - 1));

`ifdef P_ACCUM_BIAS_EN
  assign base = first ? bias : acc;
`else
  assign base = first ? '0 : acc;
`endif

  // One guard bit is enough: both operands lie within the OW-bit range.
  always_comb begin
    in_ext   = '0;
    base_ext = '0;
    sum      = '0;
    clamp    = 1'b0;
    sat_val  = '0;
    if (SGN) begin
      in_ext   = {{(OW+1-IW){in[IW-1]}}, in};
      base_ext = {base[OW-1], base};
      sum      = base_ext + in_ext;
      clamp    = sum[OW] ^ sum[OW-1];
      sat_val  = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      in_ext   = {{(OW+1-IW){1'b0}}, in};
      base_ext = {1'b0, base};
      sum      = base_ext + in_ext;
      clamp    = sum[OW];
      sat_val  = '1;
    end
    acc_nxt = clamp ? sat_val : sum[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_ACC: begin
        in_ready = 1'b1;
        if (accept && last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_ACC;
      end
      default: state_nxt = S_ACC;
    endcase
  end

  // acc/flags are left as-is after a result; the next first term overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      f_ovf <= 1'b0;
      f_udf <= 1'b0;
      f_rnd <= 1'b0;
    end else if (accept) begin
      cnt   <= last ? '0 : cnt + 1'b1;
      acc   <= acc_nxt;
      f_ovf <= (first ? 1'b0 : f_ovf) | in_ovf | clamp;
      f_udf <= (first ? 1'b0 : f_udf) | in_udf;
      f_rnd <= (first ? 1'b0 : f_rnd) | in_rounded;
    end
  end

  assign out         = acc;
  assign out_ovf     = f_ovf;
  assign out_udf     = f_udf;
  assign out_rounded = f_rnd;

endmodule

// File: tb/tb_p_accum.sv
// Bench for p_accum: signed INT prec 8, NTERMS=4; directed cases then random results vs an integer model.
module tb_p_accum;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in = '0;
  logic       in_ovf = 1'b0, in_udf = 1'b0, in_rounded = 1'b0;
`ifdef P_ACCUM_BIAS_EN
  logic [7:0] bias = '0;
`endif
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic       out_ovf, out_udf, out_rounded;

  int errors = 0;
  int checks = 0;

  // reference: plain integers, clamped to the signed 8-bit range after every add
  int macc  = 0;
  int mbase = 0;
  int mn    = 0;
  bit movf, mudf, mrnd;

  always #5 clk = ~clk;

  p_accum #(.NTERMS(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .in_ovf(in_ovf), .in_udf(in_udf), .in_rounded(in_rounded),
`ifdef P_ACCUM_BIAS_EN
    .bias(bias),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_ovf(out_ovf), .out_udf(out_udf), .out_rounded(out_rounded)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_step(input int v, input bit o, input bit u, input bit r);
    if (mn == 0) begin
      macc = mbase; movf = 0; mudf = 0; mrnd = 0;
    end
    macc += v;
    if (macc > 127)  begin macc = 127;  movf = 1; end
    if (macc < -128) begin macc = -128; movf = 1; end
    movf |= o; mudf |= u; mrnd |= r;
    mn = (mn + 1) % N;
  endtask

  task automatic put(input int v, input bit o, input bit u, input bit r, input int bubble);
    int n = 0;
    in_valid = 1'b1; in = 8'(v); in_ovf = o; in_udf = u; in_rounded = r;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("put_ready", 32'(in_ready), 32'd1);
    chk("acc_valid_low", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_ovf = 1'b0; in_udf = 1'b0; in_rounded = 1'b0;
    model_step(v, o, u, r);
    repeat (bubble) begin @(posedge clk); #1; end
  endtask

  task automatic get(input string tag, input int hold);
    logic [7:0] held;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, {{24{out[7]}}, out}, 32'(macc));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(movf));
    chk({tag, "_udf"}, 32'(out_udf), 32'(mudf));
    chk({tag, "_rnd"}, 32'(out_rounded), 32'(mrnd));
    held = out;
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_out"}, 32'(out), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_back_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_back_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flags", 32'({out_ovf, out_udf, out_rounded}), 32'd0);

    // 1: bubble after the second term, valid right after the 4th accept
    put(10, 0, 0, 0, 0); put(20, 0, 0, 0, 2); put(-5, 0, 0, 0, 0); put(7, 0, 0, 0, 0);
    chk("t1_expect32", 32'(macc), 32'd32);
    get("t1", 0);

    // 2: clamp at 127 on the second term, accumulation continues from 127
    put(100, 0, 0, 0, 0); put(100, 0, 0, 0, 0); put(-50, 0, 0, 0, 0); put(0, 0, 0, 0, 0);
    chk("t2_expect77", 32'(macc), 32'd77);
    get("t2", 0);

    // 3: held result with in_valid high, then fresh terms
    put(1, 0, 0, 0, 0); put(2, 0, 0, 0, 0); put(3, 0, 0, 0, 0); put(4, 0, 0, 0, 0);
    in_valid = 1'b1; in = 8'd99;
    get("t3", 5);
    put(5, 0, 0, 0, 0); put(6, 0, 0, 0, 0); put(-7, 0, 0, 0, 0); put(8, 0, 0, 0, 0);
    get("t3_next", 0);

    // 4: udf on term 2 only, then a clean result
    put(1, 0, 0, 0, 0); put(2, 0, 1, 0, 0); put(3, 0, 0, 0, 0); put(4, 0, 0, 0, 0);
    get("t4", 0);
    put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0);
    get("t4_clean", 0);

    // 5: reset mid-accumulation discards the partial sum
    put(50, 0, 0, 0, 0); put(50, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mn = 0;
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0);
    chk("t5_expect4", 32'(macc), 32'd4);
    get("t5", 0);

`ifdef P_ACCUM_BIAS_EN
    // 6: bias seeds the first term
    bias = 8'hFD; mbase = -3;
    put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0); put(1, 0, 0, 0, 0);
    get("t6a", 0);
    bias = 8'h80; mbase = -128;
    put(-1, 0, 0, 0, 0); put(0, 0, 0, 0, 0); put(0, 0, 0, 0, 0); put(0, 0, 0, 0, 0);
    get("t6b", 0);
    bias = '0; mbase = 0;
`endif

    // random results with bubbles, sparse flags and random hold lengths
    for (int k = 0; k < 30; k++) begin
      for (int t = 0; t < N; t++) begin
        logic [7:0] rv;
        rv = 8'($urandom);
        put(int'($signed(rv)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), (t == N - 1) ? 0 : int'($urandom_range(0, 2)));
      end
      get("rnd", int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
